// File: rtl/gmii_tx_arbiter_if.sv
// Shared GMII transmit arbitration bundle: per-source request/data/strobe in, grant and muxed byte stream out.
// Latency: none, this is only a signal container.
// Backpressure: none; sources are paced by the one-hot grant.
// Ports: req[NREQ], d_in[8*NREQ], strobe_in[NREQ] from sources; grant[NREQ], d_out[8], strobe_out, busy from arbiter.
// Modports: master = arbiter side, slave = packet-source side.
interface gmii_tx_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] d_in;
  logic [NREQ-1:0]   strobe_in;
  logic [NREQ-1:0]   grant;
  logic [7:0]        d_out;
  logic              strobe_out;
  logic              busy;

  modport master (
    input  req, d_in, strobe_in,
    output grant, d_out, strobe_out, busy
  );

  modport slave (
    output req, d_in, strobe_in,
    input  grant, d_out, strobe_out, busy
  );
endinterface

// File: rtl/gmii_tx_arbiter.sv
// Round-robin arbiter sharing one GMII TX byte stream between NREQ packet sources, with forced inter-packet gap.
// Latency: request to grant 1 cycle; granted byte to d_out/strobe_out exactly 1 cycle (registered).
// Backpressure: none on the byte path; sources wait for their one-hot grant, losers simply hold req.
// Ports: clk, rst_n (async active-low); bus (gmii_tx_arbiter_if.master): req/d_in/strobe_in in, grant/d_out/strobe_out/busy out.
// Optional macro GMII_ARB_TIMEOUT_EN: adds the WAIT-state timeout that revokes a grant never followed by strobe.
module gmii_tx_arbiter #(
  parameter int NREQ    = 2,
  parameter int IFG     = 12,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  gmii_tx_arbiter_if.master bus
);

  localparam int             PW     = $clog2(NREQ);
  localparam int             GW     = $clog2(IFG + 1);
  localparam logic [PW:0]    NREQ_W = (PW + 1)'(NREQ);

  // Elaboration-time guard on the legal parameter ranges.
  if (NREQ < 2 || NREQ > 4 || IFG < 1 || IFG > 255 || TIMEOUT < 2 || TIMEOUT > 1023) begin : g_param_chk
    $error("gmii_tx_arbiter: parameter out of legal range");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_GAP} state_e;

  state_e          state_q;
  logic [PW-1:0]   ptr_q;
  logic [NREQ-1:0] grant_q;
  logic [7:0]      d_out_q;
  logic            strobe_out_q;
  logic            busy_q;
  logic [GW-1:0]   gap_q;

  // Round-robin pick: rotate req so ptr_q lands at bit 0, take the lowest set bit,
  // then rotate the offset back into an absolute source index.
  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic              pick_vld;
  logic [PW-1:0]     pick_off;
  logic [PW:0]       win_sum;
  logic [PW-1:0]     win_idx;
  logic [PW:0]       nxt_sum;
  logic [PW-1:0]     ptr_d;
  logic [NREQ-1:0]   grant_d;

  assign req_dbl  = {bus.req, bus.req};
  assign req_rot  = req_dbl[ptr_q +: NREQ];
  assign pick_vld = |req_rot;

  always_comb begin
    pick_off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) pick_off = PW'(k);
    end
  end

  assign win_sum = {1'b0, ptr_q} + {1'b0, pick_off};
  assign win_idx = (win_sum >= NREQ_W) ? PW'(win_sum - NREQ_W) : win_sum[PW-1:0];
  assign nxt_sum = {1'b0, win_idx} + (PW + 1)'(1);
  assign ptr_d   = (nxt_sum == NREQ_W) ? '0 : nxt_sum[PW-1:0];
  assign grant_d = NREQ'(1) << win_idx;

  // Only the granted source can influence the output; everything else is masked.
  logic       g_stb;
  logic       g_req;
  logic [7:0] g_dat;

  assign g_stb = |(bus.strobe_in & grant_q);
  assign g_req = |(bus.req & grant_q);

  always_comb begin
    g_dat = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) g_dat = g_dat | bus.d_in[8*i +: 8];
    end
  end

  // Saturating gap down-counter; arbitration happens in the cycle it reaches zero.
  logic [GW-1:0] gap_d;
  assign gap_d = (gap_q == '0) ? '0 : gap_q - GW'(1);

  logic tmo_hit;
`ifdef GMII_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q;
  logic [TW-1:0] tmo_d;
  assign tmo_d   = (tmo_q == '0) ? '0 : tmo_q - TW'(1);
  assign tmo_hit = (tmo_d == '0);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      grant_q      <= '0;
      d_out_q      <= '0;
      strobe_out_q <= 1'b0;
      busy_q       <= 1'b0;
      gap_q        <= '0;
`ifdef GMII_ARB_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            busy_q  <= 1'b1;
            state_q <= S_WAIT;
`ifdef GMII_ARB_TIMEOUT_EN
            tmo_q   <= TW'(TIMEOUT);
`endif
          end
        end
        S_WAIT: begin
`ifdef GMII_ARB_TIMEOUT_EN
          tmo_q <= tmo_d;
`endif
          // A strobe wins over a simultaneous req drop: the packet has started.
          if (g_stb) begin
            d_out_q      <= g_dat;
            strobe_out_q <= 1'b1;
            state_q      <= S_XFER;
          end else if (!g_req || tmo_hit) begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_XFER: begin
          if (g_stb) begin
            d_out_q <= g_dat;
          end else begin
            d_out_q      <= '0;
            strobe_out_q <= 1'b0;
            grant_q      <= '0;
            gap_q        <= GW'(IFG);
            state_q      <= S_GAP;
          end
        end
        S_GAP: begin
          gap_q <= gap_d;
          if (gap_d == '0) begin
            if (pick_vld) begin
              grant_q <= grant_d;
              ptr_q   <= ptr_d;
              state_q <= S_WAIT;
`ifdef GMII_ARB_TIMEOUT_EN
              tmo_q   <= TW'(TIMEOUT);
`endif
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.d_out      = d_out_q;
  assign bus.strobe_out = strobe_out_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Bench for gmii_tx_arbiter: three sources, IFG=4, TIMEOUT=8.
// Expected bytes (with their due cycle) and expected grants (with the required gap) are queued by the
// source drivers and consumed by a negedge monitor.
module tb_gmii_tx_arbiter;

  localparam int NREQ    = 3;
  localparam int IFG     = 4;
  localparam int TIMEOUT = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gmii_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  gmii_tx_arbiter #(
    .NREQ    (NREQ),
    .IFG     (IFG),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic       src_req [NREQ];
  logic       src_stb [NREQ];
  logic [7:0] src_dat [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_src
    assign bus.req[i]         = src_req[i];
    assign bus.strobe_in[i]   = src_stb[i];
    assign bus.d_in[8*i +: 8] = src_dat[i];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct { logic [7:0] dat; int cyc; } byte_exp_t;
  typedef struct { int src; int gap; } gnt_exp_t;

  byte_exp_t exp_q[$];
  gnt_exp_t  gq[$];

  int              fall_cyc = -1000;
  logic            so_prev  = 1'b0;
  logic [NREQ-1:0] gnt_prev = '0;
  int              aa_cnt   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at cycle %0d", tag, act, exp, cyc);
    end
  endtask

  // Output monitor: byte scoreboard, 1-cycle latency, idle data, grant order and gap timing.
  always @(negedge clk) begin : mon
    byte_exp_t e;
    gnt_exp_t  g;
    if (rst_n) begin
      if (bus.strobe_out) begin
        if (bus.d_out == 8'hAA) aa_cnt <= aa_cnt + 1;
        if (exp_q.size() == 0) begin
          chk("byte_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("d_out", 32'(bus.d_out), 32'(e.dat));
          chk("byte_latency", 32'(cyc), 32'(e.cyc));
        end
        if (!so_prev) chk("ifg_min", 32'((cyc - fall_cyc) >= IFG + 1), 32'd1);
      end else begin
        chk("d_out_idle", 32'(bus.d_out), 32'd0);
        if (so_prev) fall_cyc <= cyc;
      end
      chk("grant_onehot", 32'($onehot0(bus.grant)), 32'd1);
      if (bus.grant != '0 && gnt_prev == '0) begin
        if (gq.size() == 0) begin
          chk("grant_unexpected", 32'(gq.size()), 32'd1);
        end else begin
          g = gq.pop_front();
          chk("grant_src", 32'(bus.grant), 32'd1 << g.src);
          if (g.gap >= 0) chk("grant_gap", 32'(cyc - fall_cyc), 32'(g.gap));
        end
      end
      so_prev  <= bus.strobe_out;
      gnt_prev <= bus.grant;
    end else begin
      so_prev  <= 1'b0;
      gnt_prev <= '0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input logic [1:0] s);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!bus.grant[s] && n < 400);
    chk("grant_wait", 32'(bus.grant[s]), 32'd1);
  endtask

  task automatic send_bytes(input logic [1:0] s, input logic [7:0] base, input int nb);
    for (int b = 0; b < nb; b++) begin
      src_stb[s] = 1'b1;
      src_dat[s] = base + 8'(b);
      exp_q.push_back('{dat: base + 8'(b), cyc: cyc + 1});
      tick();
    end
    src_stb[s] = 1'b0;
    src_dat[s] = 8'h00;
  endtask

  // Source with req held across npkt back-to-back 4-byte packets, strobing as soon as granted.
  task automatic src_run(input logic [1:0] s, input int npkt, input logic [7:0] base);
    src_req[s] = 1'b1;
    for (int p = 0; p < npkt; p++) begin
      wait_grant(s);
      send_bytes(s, base + 8'(4 * p), 4);
      if (p == npkt - 1) src_req[s] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < NREQ; i++) begin
      src_req[i] = 1'b0;
      src_stb[i] = 1'b0;
      src_dat[i] = 8'h00;
    end

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_strobe_out", 32'(bus.strobe_out), 32'd0);
    chk("rst_d_out", 32'(bus.d_out), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // All three requesting continuously: grants 0,1,2,0 with exact IFG after each strobe_out fall.
    gq.push_back('{src: 0, gap: -1});
    gq.push_back('{src: 1, gap: IFG});
    gq.push_back('{src: 2, gap: IFG});
    gq.push_back('{src: 0, gap: IFG});
    fork
      src_run(2'd0, 2, 8'h20);
      src_run(2'd1, 1, 8'h40);
      src_run(2'd2, 1, 8'h60);
    join
    repeat (IFG + 2) tick();

    // Single source 0: 5 bytes 0x55..0x59, starting 2 cycles after grant.
    gq.push_back('{src: 0, gap: -1});
    src_req[0] = 1'b1;
    tick();
    chk("t1_grant_lat", 32'(bus.grant), 32'b001);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    tick();
    tick();
    send_bytes(2'd0, 8'h55, 5);
    src_req[0] = 1'b0;
    tick();
    chk("t1_grant_drop", 32'(bus.grant), 32'd0);
    chk("t1_strobe_end", 32'(bus.strobe_out), 32'd0);
    repeat (IFG - 1) tick();
    chk("t1_gap_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("t1_idle_busy", 32'(bus.busy), 32'd0);

    // Source 1 strobes 0xAA without a grant while source 0 sends its packet.
    src_stb[1] = 1'b1;
    src_dat[1] = 8'hAA;
    gq.push_back('{src: 0, gap: -1});
    src_req[0] = 1'b1;
    wait_grant(2'd0);
    tick();
    send_bytes(2'd0, 8'h10, 4);
    src_req[0] = 1'b0;
    repeat (IFG + 2) tick();
    src_stb[1] = 1'b0;
    src_dat[1] = 8'h00;
    chk("t3_aa_leak", 32'(aa_cnt), 32'd0);

`ifdef GMII_ARB_TIMEOUT_EN
    // Source 0 granted but silent: grant revoked after TIMEOUT, source 1 granted next cycle.
    gq.push_back('{src: 0, gap: -1});
    gq.push_back('{src: 1, gap: -1});
    src_req[0] = 1'b1;
    tick();
    chk("t4_grant0", 32'(bus.grant), 32'b001);
    src_req[1] = 1'b1;
    n = 0;
    while (bus.grant[0] && n < 50) begin
      tick();
      n++;
    end
    chk("t4_timeout_len", 32'(n), 32'(TIMEOUT));
    chk("t4_busy_idle", 32'(bus.busy), 32'd0);
    src_req[0] = 1'b0;
    tick();
    chk("t4_grant1_nogap", 32'(bus.grant), 32'b010);
    send_bytes(2'd1, 8'hC0, 2);
    src_req[1] = 1'b0;
    repeat (IFG + 2) tick();
`else
    // Without the timeout, a silent granted source keeps the grant until its req falls.
    gq.push_back('{src: 0, gap: -1});
    src_req[0] = 1'b1;
    tick();
    chk("t4_grant0", 32'(bus.grant), 32'b001);
    repeat (3 * TIMEOUT) tick();
    chk("t4_grant_held", 32'(bus.grant), 32'b001);
    chk("t4_busy_held", 32'(bus.busy), 32'd1);
    src_req[0] = 1'b0;
    tick();
    chk("t4_req_drop_grant", 32'(bus.grant), 32'd0);
    chk("t4_req_drop_busy", 32'(bus.busy), 32'd0);
    n = 0;
`endif

    // req falls while in WAIT: grant drops after the next edge, back to IDLE.
    gq.push_back('{src: 2, gap: -1});
    src_req[2] = 1'b1;
    tick();
    chk("t5_grant2", 32'(bus.grant), 32'b100);
    tick();
    chk("t5_grant2_wait", 32'(bus.grant), 32'b100);
    src_req[2] = 1'b0;
    tick();
    chk("t5_grant_drop", 32'(bus.grant), 32'd0);
    chk("t5_busy", 32'(bus.busy), 32'd0);
    tick();

    // Reset mid-packet on byte 3; afterwards the pointer restarts at source 0.
    gq.push_back('{src: 0, gap: -1});
    src_req[0] = 1'b1;
    wait_grant(2'd0);
    for (int b = 0; b < 3; b++) begin
      src_stb[0] = 1'b1;
      src_dat[0] = 8'h81 + 8'(b);
      exp_q.push_back('{dat: 8'h81 + 8'(b), cyc: cyc + 1});
      tick();
    end
    src_dat[0] = 8'h84;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_grant", 32'(bus.grant), 32'd0);
    chk("t6_rst_strobe_out", 32'(bus.strobe_out), 32'd0);
    chk("t6_rst_d_out", 32'(bus.d_out), 32'd0);
    chk("t6_rst_busy", 32'(bus.busy), 32'd0);
    chk("t6_bytes_drained", 32'(exp_q.size()), 32'd0);
    src_req[0] = 1'b0;
    src_stb[0] = 1'b0;
    src_dat[0] = 8'h00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    gq.push_back('{src: 0, gap: -1});
    src_req[0] = 1'b1;
    src_req[2] = 1'b1;
    tick();
    chk("t6_first_grant", 32'(bus.grant), 32'b001);
    src_req[0] = 1'b0;
    src_req[2] = 1'b0;
    tick();
    chk("t6_grant_drop", 32'(bus.grant), 32'd0);
    chk("t6_busy", 32'(bus.busy), 32'd0);

    repeat (5) tick();
    chk("end_byte_queue", 32'(exp_q.size()), 32'd0);
    chk("end_grant_queue", 32'(gq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
